pspl_n_timed: RTL and testbench
===============================

// Module: pspl_n_timed
// PURPOSE
//  Parametrised successor of the two-way pulse splitter: one SFQ input pulse fans out to N_OUT outputs.
//  Cycle-accurate behavioural model on a fine time-step clock (1 tick = 1 ps).
//  Delay is set by a runtime bias-level index, replacing the elaboration-time bias parameter.
//  Tracks multiple pulses in flight and enforces a minimum pulse separation.
//  Used in gate-level SFQ netlists where clock/data trees need 1:N splitting.
// PARAMETERS
//  N_OUT    2  number of outputs (>=2); splitter stages STG = max(1,$clog2(N_OUT))
//  MIN_SEP  4  minimum ticks between accepted input pulses
//  DEPTH    8  in-flight pulse slots
//  TS_W     8  timestamp width; elaboration error if 16*STG >= 2**TS_W
//  CNT_W    8  violation-counter width (PSPL_VIOL_CNT_EN only)
// PORTS
//  clk       in   1        time-step clock, 1 tick per cycle
//  rst       in   1        asynchronous reset, active-high
//  a         in   1        input pulse; each cycle sampled high = one pulse
//  bias_idx  in   4        bias level 0..11 = 70%..125% in 5% steps; values >11 clamp to 11
//  y         out  N_OUT    output pulses; all bits identical
//  busy      out  1        at least one slot valid
//  viol      out  1        one-cycle flag: a pulse was rejected
//  viol_cnt  out  CNT_W    saturating rejected-pulse count (PSPL_VIOL_CNT_EN only)
// BEHAVIOUR
//  - Reset (async): all slots invalid, timestamp counter = 0, separation tracker = "none since reset",
//    y = 0, busy = 0, viol = 0, viol_cnt = 0. Pulses in flight are discarded and never emitted.
//  - ts: free-running TS_W-bit counter; wraps modulo 2**TS_W.
//  - Delay D = STG * BIAS_LUT[clamp(bias_idx)], with BIAS_LUT = {16,13,12,10,9,9,8,7,7,6,6,6} ticks.
//    D is latched when the pulse is accepted. Changing bias_idx never alters pulses already in flight.
//  - Accept rule: a pulse is accepted when a=1, at least MIN_SEP cycles have passed since the last
//    accepted pulse (or none since reset), and a free slot exists.
//    On acceptance the lowest free slot stores release = ts + D (mod 2**TS_W).
//  - Reject: sep too short OR all DEPTH slots valid -> pulse dropped; viol = 1 in the next cycle.
//    A rejected pulse does not restart the separation timer.
//  - Latency: a sampled high at edge k -> y = all-ones for exactly one cycle after edge k+D.
//  - Release: a slot whose release == ts is freed and raises y. Several slots releasing in the
//    same cycle (possible after a bias change) merge into one y pulse.
//  - Simultaneous release and accept in one cycle: the freed slot is reusable in the next cycle, not the same one.
//  - busy = OR of slot valids (registered, same cycle as slot state).
// CONFIGURATION
//  PSPL_VIOL_CNT_EN defined: viol_cnt port present; increments on each viol and saturates at all-ones.
//  PSPL_VIOL_CNT_EN undefined: no viol_cnt port and no counter logic; viol is still produced.
// STRUCTURE
//  Package sfq_cell_pkg: NUM_BIAS=12, BIAS_LUT array, function clamp_bias(), function pspl_stages(n).
//  Sub-module pspl_slot: one in-flight entry (valid, release stamp, load/match/clear). Instantiated DEPTH times.
// TESTING
//  - rst=1 mid-flight (pulse accepted, D=16): y stays 0 forever after; busy=0, viol=0 immediately.
//  - bias_idx=0, N_OUT=2: a at tick 10 -> y=2'b11 only at tick 26. bias_idx=11 -> tick 16. bias_idx=15 -> tick 16 (clamped).
//  - N_OUT=4, bias_idx=6: a at 0 -> y=4'hF at tick 16 (STG=2, 2*8).
//  - MIN_SEP=4: pulses at ticks 0,2,4 -> tick 2 rejected (viol at 3); ticks 0 and 4 emitted at +D.
//    With PSPL_VIOL_CNT_EN: viol_cnt=1.
//  - DEPTH=2, MIN_SEP=1, bias 0: pulses at 0,1,2 -> third rejected (full); y at ticks 16 and 17 only.
//  - Bias change: pulse at 0 with bias 0 (D=16), pulse at 4 with bias 11 (D=6) -> y at 10 then 16.
//    Timestamp wrap: pulse at ts=250 with D=16 is emitted 16 ticks later.

Source files
------------

// File: rtl/sfq_cell_pkg.sv
// rtl/sfq_cell_pkg.sv - shared SFQ cell constants: bias delay table and splitter stage count
package sfq_cell_pkg;

  localparam int NUM_BIAS = 12;

  // Per-stage delay in ticks for bias levels 70%..125% in 5% steps
  localparam logic [4:0] BIAS_LUT [NUM_BIAS] = '{
    5'd16, 5'd13, 5'd12, 5'd10, 5'd9, 5'd9, 5'd8, 5'd7, 5'd7, 5'd6, 5'd6, 5'd6
  };

  function automatic logic [3:0] clamp_bias(input logic [3:0] idx);
    return (idx > 4'(NUM_BIAS - 1)) ? 4'(NUM_BIAS - 1) : idx;
  endfunction

  function automatic int pspl_stages(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pspl_slot.sv
// rtl/pspl_slot.sv - one in-flight pulse entry: valid flag plus release timestamp
module pspl_slot #(
  parameter int TS_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [TS_W-1:0] stamp,
  input  logic [TS_W-1:0] ts,
  output logic            valid,
  output logic            match
);

  logic [TS_W-1:0] rel_ts;
  logic            clear;

  assign match = valid && (rel_ts == ts);
  assign clear = match;

  // load is only ever raised for a free slot, so it never collides with clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      rel_ts <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      rel_ts <= stamp;
    end else if (clear) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pspl_n_timed.sv
// rtl/pspl_n_timed.sv - timed 1:N SFQ pulse splitter with runtime bias delay; PSPL_VIOL_CNT_EN adds viol_cnt
module pspl_n_timed
  import sfq_cell_pkg::*;
#(
  parameter int N_OUT   = 2,
  parameter int MIN_SEP = 4,
  parameter int DEPTH   = 8,
  parameter int TS_W    = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [3:0]       bias_idx,
  output logic [N_OUT-1:0] y,
  output logic             busy,
  output logic             viol
`ifdef PSPL_VIOL_CNT_EN
  ,
  output logic [CNT_W-1:0] viol_cnt
`endif
);

  localparam int STG   = pspl_stages(N_OUT);
  localparam int SEP_W = (MIN_SEP < 1) ? 1 : $clog2(MIN_SEP + 1);

  if (16 * STG >= 2 ** TS_W) begin : g_ts_too_narrow
    $error("pspl_n_timed: TS_W too narrow for the longest delay");
  end
  if (N_OUT < 2 || DEPTH < 1 || CNT_W < 1) begin : g_bad_params
    $error("pspl_n_timed: N_OUT must be >= 2, DEPTH and CNT_W >= 1");
  end

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  delay;
  logic [TS_W-1:0]  stamp;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] load;
  logic [SEP_W-1:0] sep_cnt;
  logic             sep_seen;
  logic             sep_ok;
  logic             accept;
  logic             reject;

  assign delay  = TS_W'(STG * int'(BIAS_LUT[clamp_bias(bias_idx)]));
  assign stamp  = ts + delay;
  assign sep_ok = !sep_seen || (sep_cnt >= SEP_W'(MIN_SEP));
  assign accept = a && sep_ok && (|free_oh);
  assign reject = a && !accept;
  assign load   = accept ? free_oh : '0;
  assign busy   = |valid;

  // Scan high to low so the lowest free slot is the one left selected
  always_comb begin
    free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pspl_slot #(.TS_W(TS_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .stamp (stamp),
      .ts    (ts),
      .valid (valid[g]),
      .match (match[g])
    );
  end

  // sep_cnt counts edges since the last accept and parks at MIN_SEP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts       <= '0;
      sep_cnt  <= '0;
      sep_seen <= 1'b0;
      y        <= '0;
      viol     <= 1'b0;
    end else begin
      ts   <= ts + 1'b1;
      y    <= {N_OUT{|match}};
      viol <= reject;
      if (accept) begin
        sep_seen <= 1'b1;
        sep_cnt  <= SEP_W'(1);
      end else if (sep_cnt < SEP_W'(MIN_SEP)) begin
        sep_cnt  <= sep_cnt + 1'b1;
      end
    end
  end

`ifdef PSPL_VIOL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_cnt <= '0;
    end else if (reject && (viol_cnt != '1)) begin
      viol_cnt <= viol_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pspl_n_timed.sv
// tb/tb_pspl_n_timed.sv - scoreboard bench for pspl_n_timed on two configurations
module tb_pspl_n_timed;

  localparam int NI = 2;
  localparam int MS  [NI] = '{4, 1};
  localparam int DP  [NI] = '{8, 2};
  localparam int ST  [NI] = '{1, 2};
  localparam int LUT [12] = '{16, 13, 12, 10, 9, 9, 8, 7, 7, 6, 6, 6};

  typedef struct {
    int t;
    bit v;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic [3:0] bias_idx = 4'd0;
  logic [1:0] y0;
  logic [3:0] y1;
  logic       busy0, busy1, viol0, viol1;
`ifdef PSPL_VIOL_CNT_EN
  logic [7:0] vc0, vc1;
`endif

  int   yq   [NI][$];
  int   vq   [NI][$];
  ev_t  bq   [NI][$];
  int   infl [NI][$];
  int   last_acc [NI];
  bit   have_acc [NI];
  int   vcnt [NI];
  int   edges = -1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pspl_n_timed #(.N_OUT(2), .MIN_SEP(4), .DEPTH(8), .TS_W(8)) dut0 (
    .clk(clk), .rst(rst), .a(a), .bias_idx(bias_idx),
    .y(y0), .busy(busy0), .viol(viol0)
`ifdef PSPL_VIOL_CNT_EN
    , .viol_cnt(vc0)
`endif
  );

  pspl_n_timed #(.N_OUT(4), .MIN_SEP(1), .DEPTH(2), .TS_W(8)) dut1 (
    .clk(clk), .rst(rst), .a(a), .bias_idx(bias_idx),
    .y(y1), .busy(busy1), .viol(viol1)
`ifdef PSPL_VIOL_CNT_EN
    , .viol_cnt(vc1)
`endif
  );

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= -1;
    else     edges <= edges + 1;
  end

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      yq[i].delete(); vq[i].delete(); bq[i].delete(); infl[i].delete();
      have_acc[i] = 1'b0; last_acc[i] = 0; vcnt[i] = 0;
    end
  endtask

  // Reference: pulse list of emit times; a pulse holds a slot up to and including its emit edge
  task automatic model_edge(input int n, input bit av, input logic [3:0] b);
    for (int i = 0; i < NI; i++) begin
      int d, bi, occ;
      bit acc, dup;
      int keep[$];
      bi  = (b > 4'd11) ? 11 : int'(b);
      d   = ST[i] * LUT[bi];
      occ = infl[i].size();
      acc = av && (!have_acc[i] || (n - last_acc[i] >= MS[i])) && (occ < DP[i]);
      keep.delete();
      for (int j = 0; j < infl[i].size(); j++)
        if (infl[i][j] != n) keep.push_back(infl[i][j]);
      infl[i] = keep;
      if (acc) begin
        infl[i].push_back(n + d);
        have_acc[i] = 1'b1;
        last_acc[i] = n;
        dup = 1'b0;
        for (int j = 0; j < yq[i].size(); j++)
          if (yq[i][j] == n + d) dup = 1'b1;
        if (!dup) yq[i].push_back(n + d);
      end else if (av) begin
        vq[i].push_back(n);
        if (vcnt[i] < 255) vcnt[i]++;
      end
      bq[i].push_back(ev_t'{t: n, v: (infl[i].size() > 0)});
    end
  endtask

  task automatic step(input bit av, input logic [3:0] b);
    @(negedge clk);
    a = av;
    bias_idx = b;
    model_edge(edges + 1, av, b);
  endtask

  always @(negedge clk) begin
    if (!rst && edges >= 0) begin
      for (int i = 0; i < NI; i++) begin
        bit yany, yfull, vv, bb;
        int yi, vi;
        yany  = (i == 0) ? |y0 : |y1;
        yfull = (i == 0) ? (y0 == 2'b11) : (y1 == 4'hF);
        vv    = (i == 0) ? viol0 : viol1;
        bb    = (i == 0) ? busy0 : busy1;
        yi = -1;
        for (int j = 0; j < yq[i].size(); j++) if (yq[i][j] == edges) yi = j;
        vi = -1;
        for (int j = 0; j < vq[i].size(); j++) if (vq[i][j] == edges) vi = j;
        if (yany || yi >= 0) begin
          checks++;
          if (!yany || !yfull || yi < 0) begin
            errors++;
            $display("FAIL y inst=%0d tick=%0d got=%h expected_pulse=%0d", i, edges,
                     (i == 0) ? {2'b00, y0} : y1, (yi >= 0));
          end
        end
        if (yi >= 0) yq[i].delete(yi);
        if (vv || vi >= 0) begin
          checks++;
          if (vv != (vi >= 0)) begin
            errors++;
            $display("FAIL viol inst=%0d tick=%0d got=%0b expected=%0b", i, edges, vv, (vi >= 0));
          end
        end
        if (vi >= 0) vq[i].delete(vi);
        if (bq[i].size() > 0 && bq[i][0].t == edges) begin
          checks++;
          if (bb !== bq[i][0].v) begin
            errors++;
            $display("FAIL busy inst=%0d tick=%0d got=%0b expected=%0b", i, edges, bb, bq[i][0].v);
          end
          void'(bq[i].pop_front());
        end
      end
    end
  end

  task automatic check_drained(input string tag);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (yq[i].size() != 0 || vq[i].size() != 0) begin
        errors++;
        $display("FAIL %s inst=%0d pending_y=%0d pending_viol=%0d expected=0", tag, i,
                 yq[i].size(), vq[i].size());
      end
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (y0 !== 2'b00 || y1 !== 4'h0 || busy0 || busy1 || viol0 || viol1) begin
      errors++;
      $display("FAIL reset_state y0=%h y1=%h busy=%0b%0b viol=%0b%0b expected all zero",
               y0, y1, busy0, busy1, viol0, viol1);
    end

    // Bias change mid-flight, too-close pulse, clamped bias and bias 6
    step(1, 4'd0); step(0, 4'd0); step(1, 4'd0); step(0, 4'd0); step(1, 4'd11);
    repeat (40) step(0, 4'd11);
    step(1, 4'd15); repeat (40) step(0, 4'd0);
    step(1, 4'd6);  repeat (40) step(0, 4'd0);
    step(1, 4'd0); step(1, 4'd0); step(1, 4'd0); repeat (40) step(0, 4'd0);

    begin
      logic [3:0] b = 4'd0;
      for (int k = 0; k < 700; k++) begin
        if ($urandom_range(0, 7) == 0) b = 4'($urandom_range(0, 15));
        step($urandom_range(0, 2) == 0, b);
      end
    end
    repeat (60) step(0, 4'd0);
    check_drained("drain_random");
`ifdef PSPL_VIOL_CNT_EN
    checks++;
    if (vc0 !== 8'(vcnt[0]) || vc1 !== 8'(vcnt[1])) begin
      errors++;
      $display("FAIL viol_cnt got=%0d,%0d expected=%0d,%0d", vc0, vc1, vcnt[0], vcnt[1]);
    end
`endif

    // Reset while pulses are in flight: nothing may come out afterwards
    step(1, 4'd0); repeat (5) step(0, 4'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (y0 !== 2'b00 || y1 !== 4'h0 || busy0 || busy1 || viol0 || viol1) begin
      errors++;
      $display("FAIL async_reset y0=%h y1=%h busy=%0b%0b viol=%0b%0b expected all zero",
               y0, y1, busy0, busy1, viol0, viol1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef PSPL_VIOL_CNT_EN
    checks++;
    if (vc0 !== 8'd0 || vc1 !== 8'd0) begin
      errors++;
      $display("FAIL viol_cnt_reset got=%0d,%0d expected=0", vc0, vc1);
    end
`endif
    repeat (40) step(0, 4'd0);
    step(1, 4'd3); step(1, 4'd3); repeat (40) step(0, 4'd0);
    check_drained("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
